vga_timing_gen: RTL

Produces the raster scan that drives pixel_gen and the VGA connector. It generates the pixel coordinates (pix_x/pix_y) and the active-video flag that pixel_gen consumes. It also generates hsync/vsync/de, delayed to match the pixel path latency (char ROM register) so sync lines up with RGB at the pins. All timing is parameterised; defaults are 640x480@60 (25.175 MHz pix_clk).

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/sync_delay_line.sv | 32 +++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared constants and types for the VGA raster timing block
package vga_timing_pkg;

  localparam int COORD_W     = 12;
  localparam int FRAME_CNT_W = 8;
  localparam int SYNC_DELAY_MAX = 4;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_640 = 480;
  localparam int V_FP_640     = 10;
  localparam int V_SYNC_640   = 2;
  localparam int V_BP_640     = 33;

  localparam bit SYNC_POL_LOW  = 1'b0;
  localparam bit SYNC_POL_HIGH = 1'b1;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_vec_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster coordinate and sync bundle from the timing generator
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0]     pix_x;
  logic [COORD_W-1:0]     pix_y;
  logic                   vid_active;
  logic                   line_start;
  logic                   frame_start;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   hsync;
  logic                   vsync;
  logic                   de;

  modport master (
    output pix_x, pix_y, vid_active, line_start, frame_start, frame_cnt, hsync, vsync, de
  );

  modport slave (
    input pix_x, pix_y, vid_active, line_start, frame_start, frame_cnt, hsync, vsync, de
  );

endinterface

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - N-stage shift register with synchronous reset to a per-bit value
module sync_delay_line #(
  parameter int            N       = 1,
  parameter int            W       = 3,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (N == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_stages
    logic [W-1:0] stage_q [N];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[N-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parameterised raster counters, active-video decode and delayed syncs
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_640,
  parameter int H_FP       = H_FP_640,
  parameter int H_SYNC     = H_SYNC_640,
  parameter int H_BP       = H_BP_640,
  parameter int V_ACTIVE   = V_ACTIVE_640,
  parameter int V_FP       = V_FP_640,
  parameter int V_SYNC     = V_SYNC_640,
  parameter int V_BP       = V_BP_640,
  parameter bit SYNC_POL   = SYNC_POL_LOW,
  parameter int SYNC_DELAY = 1
) (
  input  logic             pix_clk,
  input  logic             rst,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 4096");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > SYNC_DELAY_MAX) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY out of range 0..4");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic               SYNC_IDLE = ~SYNC_POL;

  logic [COORD_W-1:0]     h_q, h_d, v_q, v_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   run_q;
  logic                   active_q, line_start_q, frame_start_q, hsync_q, vsync_q;
  logic                   h_wrap, v_wrap, hs_on, vs_on;

  // run_q keeps the reset-exit wrap (last pixel -> 0,0) from counting as a frame
  always_comb begin
    h_wrap      = (h_q == H_LAST);
    v_wrap      = (v_q == V_LAST);
    h_d         = h_wrap ? '0 : h_q + 1'b1;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
      if (v_wrap && run_q) frame_cnt_d = frame_cnt_q + 1'b1;
    end
    hs_on = (h_d >= HS_FIRST) && (h_d <= HS_LAST);
    vs_on = (v_d >= VS_FIRST) && (v_d <= VS_LAST);
  end

  always_ff @(posedge pix_clk) begin
    if (!rst) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      frame_cnt_q   <= '0;
      run_q         <= 1'b0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_cnt_q   <= frame_cnt_d;
      run_q         <= 1'b1;
      active_q      <= (h_d < H_ACT) && (v_d < V_ACT);
      line_start_q  <= (h_d == '0);
      frame_start_q <= (h_d == '0) && (v_d == '0);
      hsync_q       <= hs_on ? SYNC_POL : SYNC_IDLE;
      vsync_q       <= vs_on ? SYNC_POL : SYNC_IDLE;
    end
  end

  localparam sync_vec_t SYNC_VEC_IDLE = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE, de: 1'b0};

  sync_vec_t aligned, delayed;
  assign aligned = '{hsync: hsync_q, vsync: vsync_q, de: active_q};

  sync_delay_line #(
    .N       (SYNC_DELAY),
    .W       ($bits(sync_vec_t)),
    .RST_VAL (SYNC_VEC_IDLE)
  ) u_sync_delay (
    .clk_i  (pix_clk),
    .rst_ni (rst),
    .d_i    (aligned),
    .q_o    (delayed)
  );

  assign vid.pix_x       = h_q;
  assign vid.pix_y       = v_q;
  assign vid.vid_active  = active_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.frame_cnt   = frame_cnt_q;
  assign vid.hsync       = delayed.hsync;
  assign vid.vsync       = delayed.vsync;
  assign vid.de          = delayed.de;

endmodule
